// File: rtl/soc_wb_pkg.sv
// soc_wb_pkg: Wishbone CTI/BTE codes, arbiter state enum and sizing helper
package soc_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    // Index width that stays at least one bit for a single master
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_arbiter_wb_if.sv
// soc_arbiter_wb_if: per-master request/response buses plus the shared decoder-side bus
interface soc_arbiter_wb_if #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_adr_i;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_i;
    logic [MASTERS-1:0]                 m_cyc_i;
    logic [MASTERS-1:0]                 m_stb_i;
    logic [MASTERS-1:0][SW-1:0]         m_sel_i;
    logic [MASTERS-1:0]                 m_we_i;
    logic [MASTERS-1:0][2:0]            m_cti_i;
    logic [MASTERS-1:0][1:0]            m_bte_i;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_o;
    logic [MASTERS-1:0]                 m_ack_o;
    logic [MASTERS-1:0]                 m_err_o;
    logic [MASTERS-1:0]                 m_rty_o;

    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o;
    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic [SW-1:0]         s_sel_o;
    logic                  s_we_o;
    logic [2:0]            s_cti_o;
    logic [1:0]            s_bte_o;
    logic [DATA_WIDTH-1:0] s_dat_i;
    logic                  s_ack_i;
    logic                  s_err_i;
    logic                  s_rty_i;

    logic [MASTERS-1:0]    grant_o;

    // Arbiter side
    modport slave (
        input  m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output grant_o
    );

    // Requesting masters and decoder side
    modport master (
        output m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  grant_o
    );

endinterface

// File: rtl/soc_arbiter_rr.sv
// soc_arbiter_rr: combinational round-robin pick, searching upward from last_owner+1
module soc_arbiter_rr
    import soc_wb_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int IW      = idx_width(MASTERS)
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [MASTERS-1:0] winner
);

    // Walk from the farthest candidate to the nearest so the nearest requester wins
    always_comb begin
        winner = '0;
        for (int k = MASTERS; k >= 1; k--) begin
            if (|(req & (MASTERS'(1) << ((int'(last_owner) + k) % MASTERS))))
                winner = MASTERS'(1) << ((int'(last_owner) + k) % MASTERS);
        end
    end

endmodule

// File: rtl/soc_arbiter_wb.sv
// soc_arbiter_wb: round-robin Wishbone arbiter, MASTERS masters onto one shared bus.
// Optional watchdog on a stalled slave enabled by SOC_ARB_TIMEOUT_EN.
module soc_arbiter_wb
    import soc_wb_pkg::*;
#(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    soc_arbiter_wb_if.slave    bus
);

    localparam int IW = idx_width(MASTERS);

    arb_state_e         state, state_n;
    logic [MASTERS-1:0] grant, grant_n, winner;
    logic [IW-1:0]      last_owner, last_n, owner_idx;
    logic               owner_cyc;
    logic               tmo_err;

    soc_arbiter_rr #(.MASTERS(MASTERS), .IW(IW)) u_rr (
        .req        (bus.m_cyc_i),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Route the granted master onto the shared bus; an all-zero grant yields an idle bus
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_stb_o = 1'b0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cti_o = CTI_CLASSIC;
        bus.s_bte_o = BTE_LINEAR;
        owner_cyc   = 1'b0;
        owner_idx   = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant[i]) begin
                bus.s_adr_o = bus.m_adr_i[i];
                bus.s_dat_o = bus.m_dat_i[i];
                bus.s_stb_o = bus.m_stb_i[i];
                bus.s_sel_o = bus.m_sel_i[i];
                bus.s_we_o  = bus.m_we_i[i];
                bus.s_cti_o = bus.m_cti_i[i];
                bus.s_bte_o = bus.m_bte_i[i];
                owner_cyc   = bus.m_cyc_i[i];
                owner_idx   = IW'(i);
            end
        end
    end

    assign bus.s_cyc_o = owner_cyc;
    assign bus.grant_o = grant;

    // Responses reach only the owner; read data is broadcast but held at zero in reset
    always_comb begin
        for (int i = 0; i < MASTERS; i++)
            bus.m_dat_o[i] = rst_i ? '0 : bus.s_dat_i;
    end

    assign bus.m_ack_o = grant & {MASTERS{bus.s_ack_i}};
    assign bus.m_err_o = grant & {MASTERS{bus.s_err_i | tmo_err}};
    assign bus.m_rty_o = grant & {MASTERS{bus.s_rty_i}};

    // Next-state: arbitrate only from IDLE, release when the owner drops its cycle
    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_owner;
        if (state == ARB_IDLE) begin
            grant_n = winner;
            state_n = (|bus.m_cyc_i) ? ARB_OWNED : ARB_IDLE;
        end else if (!owner_cyc) begin
            grant_n = '0;
            last_n  = owner_idx;
            state_n = ARB_IDLE;
        end
    end

    // State register; reset makes master 0 the first winner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= IW'(MASTERS - 1);
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_owner <= last_n;
        end
    end

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          stall;

    assign stall   = bus.s_stb_o && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
    assign tmo_err = stall && (tmo_cnt == CW'(TIMEOUT - 1));

    // Count consecutive stalled strobe cycles; restart after firing or any response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else
            tmo_cnt <= (stall && !tmo_err) ? tmo_cnt + 1'b1 : '0;
    end
`else
    // No watchdog: a negative limit is impossible, so the error is never raised
    assign tmo_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_soc_arbiter_wb.sv
// tb_soc_arbiter_wb: directed scenarios plus random traffic checked against a behavioural model
module tb_soc_arbiter_wb;
    import soc_wb_pkg::*;

    localparam int M  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
`ifdef SOC_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soc_arbiter_wb_if #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    soc_arbiter_wb #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: who owns the bus, who owned it last, how long the slave has stalled
    int owner     = -1;
    int last      = M - 1;
    int stall_cnt = 0;

    function automatic bit own_cyc();
        for (int i = 0; i < M; i++) if (i == owner) return bus.m_cyc_i[i];
        return 1'b0;
    endfunction

    function automatic bit own_stb();
        for (int i = 0; i < M; i++) if (i == owner) return bus.m_stb_i[i];
        return 1'b0;
    endfunction

    function automatic bit slave_stalled();
        return own_stb() && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
    endfunction

    function automatic bit tmo_fire();
        return TMO && slave_stalled() && (stall_cnt == TO - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1;
            last = M - 1;
            stall_cnt = 0;
        end else begin
            stall_cnt = (slave_stalled() && !tmo_fire()) ? stall_cnt + 1 : 0;
            if (owner < 0) begin
                for (int k = 1; k <= M; k++) begin
                    if (bus.m_cyc_i[(last + k) % M]) begin
                        owner = (last + k) % M;
                        break;
                    end
                end
            end else if (!own_cyc()) begin
                last = owner;
                owner = -1;
            end
        end
    end

    logic [M-1:0]    e_grant;
    logic [AW-1:0]   e_adr;
    logic [DW-1:0]   e_dat;
    logic [DW/8-1:0] e_sel;
    logic            e_we;
    logic [2:0]      e_cti;
    logic [1:0]      e_bte;

    always @(negedge clk) begin
        e_grant = '0; e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cti = '0; e_bte = '0;
        for (int i = 0; i < M; i++) begin
            if (i == owner) begin
                e_grant[i] = 1'b1;
                e_adr = bus.m_adr_i[i];
                e_dat = bus.m_dat_i[i];
                e_sel = bus.m_sel_i[i];
                e_we  = bus.m_we_i[i];
                e_cti = bus.m_cti_i[i];
                e_bte = bus.m_bte_i[i];
            end
        end
        chk("grant", bus.grant_o, e_grant);
        chk("s_cyc", bus.s_cyc_o, own_cyc());
        chk("s_stb", bus.s_stb_o, own_stb());
        chk("s_req", {bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cti_o, bus.s_bte_o},
            {e_adr, e_dat, e_sel, e_we, e_cti, e_bte});
        chk("m_ack", bus.m_ack_o, e_grant & {M{bus.s_ack_i}});
        chk("m_err", bus.m_err_o, e_grant & {M{bus.s_err_i | tmo_fire()}});
        chk("m_rty", bus.m_rty_o, e_grant & {M{bus.s_rty_i}});
        chk("m_dat", bus.m_dat_o, rst ? '0 : {M{bus.s_dat_i}});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
        bus.m_sel_i = '0; bus.m_we_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    endtask

    task automatic wait_grant(output int idx, output int zeros);
        idx = -1;
        zeros = 0;
        for (int n = 0; n < 10 && idx < 0; n++) begin
            @(negedge clk);
            if (bus.grant_o != '0) begin
                for (int i = 0; i < M; i++) if (bus.grant_o[i]) idx = i;
            end else zeros++;
        end
        if (idx < 0) begin
            checks++;
            $display("FAIL grant_wait: got no grant within 10 cycles at %0t", $time);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int idx, zeros;
    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        clear_inputs();
        bus.s_dat_i = 32'h1234;
        repeat (2) @(negedge clk);
        chk("rst_grant", bus.grant_o, 2'b00);
        chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_m_dat", bus.m_dat_o, 64'h0);
        tick();
        rst = 1'b0;
        bus.s_dat_i = '0;
        tick();

        // Single read by master 0, slave acks on the second strobe cycle
        bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.m_adr_i[0] = 32'h100;
        @(negedge clk);
        chk("lat_req_cycle", bus.s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        chk("lat_one", bus.s_cyc_o, 1'b1);
        chk("lat_grant", bus.grant_o, 2'b01);
        tick();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("read_ack", bus.m_ack_o, 2'b01);
        chk("read_dat", bus.m_dat_o[0], 32'hDEADBEEF);
        tick();
        clear_inputs();
        tick();
        pulse_reset();

        // Both masters contend four times: strict alternation, one idle cycle between owners
        bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant(idx, zeros);
            chk($sformatf("rr_order_%0d", r), idx, exp_order[r]);
            chk($sformatf("idle_gap_%0d", r), zeros, 1);
            tick();
            bus.m_cyc_i[idx] = 1'b0;
            tick();
            bus.m_cyc_i[idx] = 1'b1;
        end
        clear_inputs();
        repeat (2) tick();

        // Master 1 bursts while master 0 waits: no preemption, handover 2 cycles after release
        bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1; bus.m_cti_i[1] = CTI_INCR;
        wait_grant(idx, zeros);
        chk("burst_owner", idx, 1);
        tick();
        bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.s_ack_i = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus.m_cti_i[1] = (b == 7) ? CTI_EOB : CTI_INCR;
            bus.m_adr_i[1] = 32'h200 + 32'(4 * b);
            @(negedge clk);
            chk($sformatf("burst_hold_%0d", b), bus.grant_o, 2'b10);
            tick();
        end
        bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0; bus.s_ack_i = 1'b0;
        @(negedge clk);
        chk("release_s_cyc", bus.s_cyc_o, 1'b0);
        tick();
        @(negedge clk);
        chk("release_plus1", bus.grant_o, 2'b00);
        tick();
        @(negedge clk);
        chk("release_plus2", bus.grant_o, 2'b01);
        tick();
        clear_inputs();
        repeat (2) tick();

        // Reset while master 1 owns: bus drops at once and master 0 wins afterwards
        bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
        wait_grant(idx, zeros);
        chk("pre_rst_owner", idx, 1);
        tick();
        bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1; bus.s_ack_i = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_async_grant", bus.grant_o, 2'b00);
        chk("rst_async_ack", bus.m_ack_o, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        wait_grant(idx, zeros);
        chk("post_rst_owner", idx, 0);
        tick();
        clear_inputs();
        repeat (2) tick();

        // Error and retry reach only the owner (master 1)
        bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
        wait_grant(idx, zeros);
        chk("resp_owner", idx, 1);
        tick();
        bus.s_err_i = 1'b1;
        @(negedge clk);
        chk("err_route", bus.m_err_o, 2'b10);
        chk("err_no_ack", bus.m_ack_o, 2'b00);
        tick();
        bus.s_err_i = 1'b0; bus.s_rty_i = 1'b1;
        @(negedge clk);
        chk("rty_route", bus.m_rty_o, 2'b10);
        chk("rty_no_err", bus.m_err_o, 2'b00);
        tick();
        clear_inputs();
        repeat (3) tick();

        // Slave never answers: watchdog fires every TO stalled cycles, or never without it
        bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
        wait_grant(idx, zeros);
        chk("stall_owner", idx, 0);
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            chk($sformatf("tmo_%0d", n), bus.m_err_o[0], TMO && (n % TO == 0));
        end
        tick();
        clear_inputs();
        repeat (2) tick();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < M; i++) begin
                if ($urandom_range(3) == 0) bus.m_cyc_i[i] = ~bus.m_cyc_i[i];
                bus.m_stb_i[i] = 1'($urandom_range(1));
                bus.m_adr_i[i] = $urandom;
                bus.m_dat_i[i] = $urandom;
                bus.m_sel_i[i] = 4'($urandom);
                bus.m_we_i[i]  = 1'($urandom_range(1));
                bus.m_cti_i[i] = 3'($urandom);
                bus.m_bte_i[i] = 2'($urandom);
            end
            bus.s_dat_i = $urandom;
            bus.s_ack_i = ($urandom_range(2) == 0);
            bus.s_err_i = ($urandom_range(15) == 0);
            bus.s_rty_i = ($urandom_range(15) == 0);
            if ($urandom_range(299) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        clear_inputs();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/soc_arbiter_wb.md
SOC_ARBITER_WB -- requirements
Module: soc_arbiter_wb

Interface
REQ-001 Parameter MASTERS, default 2, number of requesting Wishbone masters (1..8).
REQ-002 Parameter DATA_WIDTH, default 32, bus data width, multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-004 Parameter TIMEOUT, default 255, watchdog limit in cycles (used only with SOC_ARB_TIMEOUT_EN).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 m_adr_i/m_dat_i/m_cyc_i/m_stb_i/m_sel_i/m_we_i/m_cti_i/m_bte_i  in  MASTERS x (ADDR_WIDTH/DATA_WIDTH/1/1/DATA_WIDTH/8/1/3/2)  per-master request buses, packed [MASTERS-1:0].
REQ-008 m_dat_o  out  MASTERS x DATA_WIDTH  read data per master.
REQ-009 m_ack_o/m_err_o/m_rty_o  out  MASTERS  per-master response strobes.
REQ-010 s_adr_o/s_dat_o/s_cyc_o/s_stb_o/s_sel_o/s_we_o/s_cti_o/s_bte_o  out  ADDR_WIDTH/DATA_WIDTH/1/1/DATA_WIDTH/8/1/3/2  single shared bus toward the address decoder.
REQ-011 s_dat_i/s_ack_i/s_err_i/s_rty_i  in  DATA_WIDTH/1/1/1  shared responses from the decoder.
REQ-012 grant_o  out  MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-013 FSM has two states: IDLE and OWNED.
REQ-014 IDLE: if any m_cyc_i is high, the winner is registered into grant_o and the FSM goes to OWNED; no request keeps the FSM in IDLE.
REQ-015 Winner selection is round-robin: the first requesting index searched upward (wrapping) from last_owner+1; last_owner resets to MASTERS-1, so master 0 wins first.
REQ-016 Latency from m_cyc_i rising (in IDLE) to s_cyc_o high is exactly 1 cycle.
REQ-017 OWNED: all s_* request outputs combinationally equal the granted master's inputs; s_cyc_o and s_stb_o are 0 in IDLE.
REQ-018 OWNED: if the granted master's m_cyc_i is low, s_cyc_o drops that same cycle, last_owner takes the grant index, grant_o clears, and the FSM returns to IDLE on the next edge.
REQ-019 Each arbitration inserts one idle cycle; back-to-back owners are separated by at least one cycle with s_cyc_o low.
REQ-020 Grant is never preempted while the owner holds m_cyc_i, including across CTI bursts.
REQ-021 m_dat_o[i] = s_dat_i for every i; m_ack_o[i]/m_err_o[i]/m_rty_o[i] equal s_ack_i/s_err_i/s_rty_i AND grant_o[i]; non-owners see 0.
REQ-022 If requests arrive in the same cycle as the owner releases, they are arbitrated in the following IDLE cycle using the updated last_owner.
REQ-023 MASTERS=1 degenerates to pass-through with the 1-cycle grant latency.

Reset
REQ-024 rst_i asserted at any time clears grant_o to 0, sets FSM to IDLE, last_owner to MASTERS-1, and the watchdog counter to 0; s_cyc_o/s_stb_o go low immediately without waiting for clk_i.
REQ-025 Reset mid-transfer abandons the transfer, with no response to any master.
REQ-026 All outputs are 0 during reset.

Configuration
REQ-027 Macro SOC_ARB_TIMEOUT_EN defined: in OWNED with s_stb_o high and s_ack_i/s_err_i/s_rty_i all low, a counter increments each cycle; on reaching TIMEOUT it pulses m_err_o of the owner for one cycle (s_err_i equivalent) and clears; any response or stb low clears it.
REQ-028 Macro undefined: no counter is instantiated and a stalled slave holds the bus indefinitely.

Structure
REQ-029 Shared package soc_wb_pkg holds CTI codes (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), BTE codes, and the arbiter state enum.
REQ-030 Sub-module soc_arbiter_rr: combinational round-robin pick (req, last_owner -> one-hot winner).

Verification
REQ-031 Master 0 alone, single read with slave ack at 2nd stb cycle -> s_cyc_o high 1 cycle after m_cyc_i[0], m_ack_o=2'b01, m_dat_o[0]=s_dat_i=0xDEADBEEF.
REQ-032 Both masters request at the same time, repeated 4 times -> grants alternate 0,1,0,1 with exactly one s_cyc_o-low cycle between owners.
REQ-033 Master 1 owns and issues an 8-beat INCR burst while master 0 requests -> no preemption; master 0 is granted 2 cycles after m_cyc_i[1] falls.
REQ-034 rst_i pulsed mid-burst -> s_cyc_o low in the same cycle, grant_o=0, next grant goes to master 0.
REQ-035 With SOC_ARB_TIMEOUT_EN, TIMEOUT=4, slave never responds -> m_err_o of the owner pulses exactly on the 4th stalled cycle; without the macro, no error is ever raised.
REQ-036 Slave err and rty on the owner -> routed only to the owner; the non-owner sees all-zero responses.
